// File: rtl/mul_pkg.sv
// Shared types and defaults for the iterative integer multiplier: operation
// encodings, controller states and small operation-class helpers.
package mul_pkg;

  localparam int MUL_N_DEF     = 64;
  localparam int MUL_CHUNK_DEF = 8;
  localparam int MULW_W        = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Reserved codes 5-7 fold onto MUL.
  function automatic mul_op_t decode_op(input logic [2:0] code);
    case (code)
      3'd1:    return OP_MULH;
      3'd2:    return OP_MULHSU;
      3'd3:    return OP_MULHU;
      3'd4:    return OP_MULW;
      default: return OP_MUL;
    endcase
  endfunction

  function automatic logic a_is_signed(input mul_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic b_is_signed(input mul_op_t op);
    return (op == OP_MULH);
  endfunction

  function automatic logic is_high(input mul_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/cseladd.sv
// Carry-select adder: each BLK-bit block precomputes sums for carry-in 0 and 1,
// and the rippling block carry only drives the selecting muxes.
module cseladd #(
  parameter int W   = 128,
  parameter int BLK = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  localparam int NB = W / BLK;

  logic [NB:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLK:0] s0;
    logic [BLK:0] s1;

    assign s0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
    assign s1 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]} + (BLK+1)'(1);

    assign sum_o[g*BLK +: BLK] = carry[g] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry[g+1]          = carry[g] ? s1[BLK]     : s0[BLK];
  end

  assign cout_o = carry[NB];

endmodule

// File: rtl/mul_chunk_pp.sv
// Combinational N x CHUNK unsigned partial product: AND-gated, shifted rows of
// the multiplicand summed through a chain of carry-select adders.
module mul_chunk_pp #(
  parameter int N     = 64,
  parameter int CHUNK = 8
) (
  input  logic [N-1:0]       mcand_i,
  input  logic [CHUNK-1:0]   mplier_i,
  output logic [N+CHUNK-1:0] pp_o
);

  localparam int PW = N + CHUNK;

  logic [PW-1:0]    row  [CHUNK];
  logic [PW-1:0]    part [CHUNK];
  logic [CHUNK-1:0] unused_cout;

  for (genvar j = 0; j < CHUNK; j++) begin : g_row
    assign row[j] = {{CHUNK{1'b0}}, mcand_i & {N{mplier_i[j]}}} << j;
  end

  assign part[0]        = row[0];
  assign unused_cout[0] = 1'b0;

  for (genvar j = 1; j < CHUNK; j++) begin : g_sum
    cseladd #(
      .W   (PW),
      .BLK (CHUNK)
    ) u_add (
      .a_i    (part[j-1]),
      .b_i    (row[j]),
      .cin_i  (1'b0),
      .sum_o  (part[j]),
      .cout_o (unused_cout[j])
    );
  end

  assign pp_o = part[CHUNK-1];

endmodule

// File: rtl/int_mul_iter.sv
// Iterative sign-magnitude multiplier retiring CHUNK multiplier bits per cycle
// into a right-shifting 2N-bit accumulator, with a valid/ready result port.
module int_mul_iter
  import mul_pkg::*;
#(
  parameter int N     = MUL_N_DEF,
  parameter int CHUNK = MUL_CHUNK_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STEPS = N / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int W2    = 2 * N;

  mul_state_t       state_q, state_d;
  mul_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     result_q, result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Operand conditioning on the accept path.
  mul_op_t      op_dec;
  logic [N-1:0] a_op, b_op, a_mag, b_mag;
  logic         a_neg, b_neg;

  assign op_dec = decode_op(op);
  assign a_op   = (op_dec == OP_MULW) ? {{(N-MULW_W){1'b0}}, a[MULW_W-1:0]} : a;
  assign b_op   = (op_dec == OP_MULW) ? {{(N-MULW_W){1'b0}}, b[MULW_W-1:0]} : b;
  assign a_neg  = a_is_signed(op_dec) & a_op[N-1];
  assign b_neg  = b_is_signed(op_dec) & b_op[N-1];
  // -2^(N-1) negates to itself, which is already its correct unsigned magnitude.
  assign a_mag  = a_neg ? (~a_op + 1'b1) : a_op;
  assign b_mag  = b_neg ? (~b_op + 1'b1) : b_op;

  // Accumulation datapath: acc <- (acc >> CHUNK) + (pp << (N - CHUNK)).
  logic [N+CHUNK-1:0] pp;
  logic [W2-1:0]      acc_sum, prod;
  logic [N-1:0]       slice;
  logic               unused_acc_cout;

  mul_chunk_pp #(
    .N     (N),
    .CHUNK (CHUNK)
  ) u_pp (
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q[CHUNK-1:0]),
    .pp_o     (pp)
  );

  cseladd #(
    .W   (W2),
    .BLK (CHUNK)
  ) u_acc_add (
    .a_i    (acc_q >> CHUNK),
    .b_i    (W2'(pp) << (N - CHUNK)),
    .cin_i  (1'b0),
    .sum_o  (acc_sum),
    .cout_o (unused_acc_cout)
  );

  assign prod = neg_q ? (~acc_sum + 1'b1) : acc_sum;

  always_comb begin
    slice = prod[N-1:0];
    if (is_high(op_q)) begin
      slice = prod[W2-1:N];
    end else if (op_q == OP_MULW) begin
      slice = {{(N-MULW_W){prod[MULW_W-1]}}, prod[MULW_W-1:0]};
    end
  end

  always_comb begin
    // NOTE: every variable is given its default first, so no path can infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    out_tag_d = out_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = op_dec;
          tag_d    = tag;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> CHUNK;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          result_d  = slice;
          out_tag_d = tag_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      tag_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_tag_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_int_mul_iter.sv
// Directed and reference-model checks for int_mul_iter at default parameters:
// op slices, latency, back-pressure, flush and mid-operation reset.
module tb_int_mul_iter;

  localparam int N     = 64;
  localparam int CHUNK = 8;
  localparam int TAG_W = 5;
  localparam int LAT   = N / CHUNK + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [TAG_W-1:0] tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  int_mul_iter #(
    .N     (N),
    .CHUNK (CHUNK),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag       (tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Independent 2N-bit reference.
  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xs, ys, p;
    logic [63:0]  pw;
    case (o)
      3'd1: begin xs = {{64{x[63]}}, x}; ys = {{64{y[63]}}, y}; p = xs * ys; return p[127:64]; end
      3'd2: begin xs = {{64{x[63]}}, x}; ys = {64'd0, y};       p = xs * ys; return p[127:64]; end
      3'd3: begin xs = {64'd0, x};       ys = {64'd0, y};       p = xs * ys; return p[127:64]; end
      3'd4: begin pw = {32'd0, x[31:0]} * {32'd0, y[31:0]}; return {{32{pw[31]}}, pw[31:0]}; end
      default: begin xs = {64'd0, x}; ys = {64'd0, y}; p = xs * ys; return p[63:0]; end
    endcase
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("wait_idle", in_ready, 1'b1);
  endtask

  task automatic launch(input logic [2:0] op_v, input logic [63:0] a_v, input logic [63:0] b_v,
                        input logic [4:0] tag_v);
    in_valid = 1'b1;
    op       = op_v;
    a        = a_v;
    b        = b_v;
    tag      = tag_v;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op_v, input logic [63:0] a_v,
                        input logic [63:0] b_v, input logic [4:0] tag_v, input logic [63:0] exp_v);
    int lat;
    wait_idle();
    launch(op_v, a_v, b_v, tag_v);
    wait_valid(lat);
    check({nm, ".latency"}, lat, LAT);
    check({nm, ".result"}, result, exp_v);
    check({nm, ".tag"}, out_tag, tag_v);
    check({nm, ".in_ready_low"}, in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, ".release"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic quiet(input string nm, input int cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      seen |= out_valid;
    end
    check(nm, seen, 1'b0);
  endtask

  initial begin
    logic [63:0] corners [4];
    logic [63:0] ra, rb;
    int          lat;

    corners[0] = 64'h0000_0000_0000_0000;
    corners[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[2] = 64'h8000_0000_0000_0000;
    corners[3] = 64'h7FFF_FFFF_FFFF_FFFF;

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.flags", {in_ready, out_valid}, 2'b10);
    check("reset.result", result, 64'd0);
    check("reset.out_tag", out_tag, 5'd0);

    run_op("mul_7x6", 3'd0, 64'd7, 64'd6, 5'h13, 64'd42);
    run_op("mulh_m1xm1", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'h01, 64'd0);
    run_op("mulhu_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'h02,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_m2x3", 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'h03, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulh_minxm1", 3'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h04, 64'd0);
    run_op("mul_minxm1", 3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h05,
           64'h8000_0000_0000_0000);
    run_op("mulh_minxmin", 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'h06,
           64'h4000_0000_0000_0000);
    run_op("mulw_ovf", 3'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'h07, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhu_2e64", 3'd3, 64'h8000_0000_0000_0000, 64'd2, 5'h08, 64'd1);
    run_op("op7_as_mul", 3'd7, 64'd3, 64'd5, 5'h1F, 64'd15);

    // Back-pressure: output held for five cycles, then released.
    wait_idle();
    launch(3'd0, 64'd9, 64'd9, 5'h0A);
    wait_valid(lat);
    check("bp.latency", lat, LAT);
    for (int i = 0; i < 5; i++) begin
      check("bp.flags", {out_valid, in_ready}, 2'b10);
      check("bp.result", result, 64'd81);
      check("bp.tag", out_tag, 5'h0A);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release", {out_valid, in_ready}, 2'b01);

    // Flush sampled at the end of the third BUSY cycle.
    wait_idle();
    launch(3'd0, 64'd11, 64'd13, 5'h0B);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy.flags", {out_valid, in_ready}, 2'b01);
    quiet("flush_busy.no_valid", 12);
    run_op("after_flush", 3'd0, 64'd11, 64'd13, 5'h0C, 64'd143);

    // Reset sampled at the end of the fourth BUSY cycle.
    wait_idle();
    launch(3'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd5, 5'h0D);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy.flags", {out_valid, in_ready}, 2'b01);
    check("rst_busy.result", result, 64'd0);
    check("rst_busy.tag", out_tag, 5'd0);
    quiet("rst_busy.no_valid", 12);
    run_op("after_rst", 3'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd5, 5'h0E, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush coinciding with an accept discards the request.
    wait_idle();
    in_valid = 1'b1; op = 3'd0; a = 64'd2; b = 64'd2; tag = 5'h0F; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept.flags", {out_valid, in_ready}, 2'b01);
    quiet("flush_accept.no_valid", 12);

    // Flush while a result waits in DONE drops it.
    wait_idle();
    launch(3'd0, 64'd4, 64'd4, 5'h10);
    wait_valid(lat);
    check("flush_done.latency", lat, LAT);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done.flags", {out_valid, in_ready}, 2'b01);
    quiet("flush_done.no_valid", 12);

    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 100; k++) begin
        if (k < 16) begin
          ra = corners[k % 4];
          rb = corners[k / 4];
        end else begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
        end
        run_op("rand", o[2:0], ra, rb, 5'($urandom), ref_mul(o[2:0], ra, rb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
